// File: rtl/ntt_scheduler.sv
// ntt_scheduler: address/twiddle sequencer for an in-place radix-2 NTT over
// 2^(K+1) coefficients (K layers of 2^K butterflies), forward or inverse.
// The inverse transform is followed by 2^(K+1) scaling ops.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a transform (sampled in IDLE only)
//   inverse             0 = forward, 1 = inverse (latched with start)
//   bf_ready            butterfly unit accepts the current issue
//   pipe_empty          butterfly pipeline has nothing in flight
//   issue_valid         addr_a/addr_b/zeta_idx/scale_op are valid
//   addr_a, addr_b      coefficient indices of the issued op
//   zeta_idx            index into the bit-reversed zeta table
//   scale_op            issue is a final inverse scaling op
//   layer               current layer
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
module ntt_scheduler #(
  parameter int K = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 inverse,
  input  logic                 bf_ready,
  input  logic                 pipe_empty,
  output logic                 issue_valid,
  output logic [K:0]           addr_a,
  output logic [K:0]           addr_b,
  output logic [K-1:0]         zeta_idx,
  output logic                 scale_op,
  output logic [$clog2(K)-1:0] layer,
  output logic                 busy,
  output logic                 done
);
  localparam int LW  = $clog2(K);
  localparam int SHW = LW + 1;

  typedef logic [K-1:0]   bf_t;
  typedef logic [K:0]     ad_t;
  typedef logic [LW-1:0]  ly_t;
  typedef logic [SHW-1:0] sh_t;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SCALE, DONE} state_t;

  state_t state_q, state_d;
  ly_t    layer_q, layer_d;
  bf_t    bf_q, bf_d;
  ad_t    sc_q, sc_d;
  logic   inv_q, inv_d;
  logic   scaled_q, scaled_d;

  // Butterfly address generation from (layer, bf)
  sh_t ld, shf, shi, sh;
  bf_t g, o;
  ad_t a_bf, b_bf;
  bf_t z_bf;

  always_comb begin
    ld  = {1'b0, layer_q};
    shf = sh_t'(K) - ld;          // log2(len) for forward layers
    shi = ld + sh_t'(1);          // log2(len) for inverse layers
    sh  = inv_q ? shi : shf;
    g   = bf_q >> sh;
    // For sh == K the K-bit mask wraps to all ones, i.e. every bf bit is offset.
    o   = bf_q & ((bf_t'(1) << sh) - bf_t'(1));
    a_bf = ((ad_t'(g) << sh) << 1) | ad_t'(o);
    b_bf = a_bf + (ad_t'(1) << sh);
    // Inverse: 2^(K-L) - 1 - g taken mod 2^K, so the 2^K term at layer 0
    // wraps to zero and still yields the right index.
    z_bf = inv_q ? ((bf_t'(1) << shf) - bf_t'(1) - g)
                 : ((bf_t'(1) << ld) + g);
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    bf_d     = bf_q;
    sc_d     = sc_q;
    inv_d    = inv_q;
    scaled_d = scaled_q;
    unique case (state_q)
      IDLE: if (start) begin
        inv_d    = inverse;
        layer_d  = '0;
        bf_d     = '0;
        sc_d     = '0;
        scaled_d = 1'b0;
        state_d  = ISSUE;
      end
      ISSUE: if (bf_ready) begin
        bf_d = bf_q + bf_t'(1);
        if (bf_q == '1) state_d = DRAIN;
      end
      DRAIN: if (pipe_empty) begin
        if (layer_q != ly_t'(K - 1)) begin
          layer_d = layer_q + ly_t'(1);
          bf_d    = '0;
          state_d = ISSUE;
        end else if (!inv_q || scaled_q) begin
          state_d = DONE;
        end else begin
          sc_d    = '0;
          state_d = SCALE;
        end
      end
      SCALE: if (bf_ready) begin
        sc_d = sc_q + ad_t'(1);
        if (sc_q == '1) begin
          scaled_d = 1'b1;
          state_d  = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      bf_q     <= '0;
      sc_q     <= '0;
      inv_q    <= 1'b0;
      scaled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      bf_q     <= bf_d;
      sc_q     <= sc_d;
      inv_q    <= inv_d;
      scaled_q <= scaled_d;
    end
  end

  // Outputs are pure functions of registered state, so they stay frozen
  // while bf_ready is low and drop to zero the instant reset asserts.
  always_comb begin
    issue_valid = (state_q == ISSUE) || (state_q == SCALE);
    scale_op    = (state_q == SCALE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    layer       = layer_q;
    addr_a      = '0;
    addr_b      = '0;
    zeta_idx    = '0;
    if (state_q == ISSUE) begin
      addr_a   = a_bf;
      addr_b   = b_bf;
      zeta_idx = z_bf;
    end else if (state_q == SCALE) begin
      addr_a = sc_q;
      addr_b = sc_q;
    end
  end
endmodule

// File: tb/tb_ntt_scheduler.sv
module tb_ntt_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, start, inverse, bf_ready, pipe_empty;
  logic       issue_valid, scale_op, busy, done;
  logic [7:0] addr_a, addr_b;
  logic [6:0] zeta_idx;
  logic [2:0] layer;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ntt_scheduler #(.K(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
    .bf_ready(bf_ready), .pipe_empty(pipe_empty),
    .issue_valid(issue_valid), .addr_a(addr_a), .addr_b(addr_b),
    .zeta_idx(zeta_idx), .scale_op(scale_op), .layer(layer),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one transform from IDLE. bp: stall bf_ready 5 cycles at layer 2
  // bf 37. stall: hold pipe_empty low 10 cycles after layer 0.
  task automatic run(input bit inv, input bit bp, input bit stall, input int exp_done);
    int n_iss, n_sc, bp_left, st_left, tot, idx, L, b, len, g, ea, eb, ez, esc;
    bit got_done, bp_used, st_used, first1;
    n_iss = 0; n_sc = 0; bp_left = 0; st_left = 0;
    got_done = 0; bp_used = 0; st_used = 0; first1 = 0;
    tot = inv ? 1152 : 896;
    cyc = 0;
    inverse = inv; start = 1'b1; bf_ready = 1'b1; pipe_empty = 1'b1;
    tick();
    start = 1'b0;
    inverse = ~inv;                       // must be ignored once latched
    while (!got_done && cyc < 3000) begin
      start = (cyc >= 300 && cyc < 305);  // must be ignored while busy
      if (bp && !bp_used && issue_valid && n_iss == 2*128 + 37) begin
        bp_left = 5; bp_used = 1;
      end
      bf_ready = (bp_left == 0);
      if (bp_left > 0) begin
        chk("bp_addr_a", addr_a, 69);
        chk("bp_addr_b", addr_b, 101);
        chk("bp_zeta", zeta_idx, 5);
        bp_left--;
      end
      if (stall && !st_used && !issue_valid && n_iss == 128) begin
        st_left = 10; st_used = 1;
      end
      pipe_empty = (st_left == 0);
      if (st_left > 0) begin
        chk("stall_iv", issue_valid, 0);
        st_left--;
      end
      if (cyc == 129) begin
        chk("drain_iv", issue_valid, 0);
        chk("drain_busy", busy, 1);
      end
      if (issue_valid) begin
        if (n_iss == 0) chk("first_cyc", cyc, 1);
        if (n_iss == 128 && !first1) begin
          first1 = 1;
          chk("l1_cyc", cyc, stall ? 140 : 130);
        end
        idx = n_iss;
        if (idx < 896) begin
          L = idx / 128; b = idx % 128;
          len = inv ? (1 << (L + 1)) : (1 << (7 - L));
          g = b / len;
          ea = 2 * len * g + (b % len);
          eb = ea + len;
          ez = inv ? ((1 << (7 - L)) - 1 - g) : ((1 << L) + g);
          esc = 0;
        end else begin
          L = 6; ea = idx - 896; eb = ea; ez = 0; esc = 1;
        end
        chk("addr_a", addr_a, ea);
        chk("addr_b", addr_b, eb);
        chk("zeta", zeta_idx, ez);
        chk("scale_op", scale_op, esc);
        chk("layer", layer, L);
        if (bf_ready) begin
          n_iss++;
          if (scale_op) n_sc++;
        end
      end else begin
        chk("idle_scale_op", scale_op, 0);
      end
      if (done) begin
        got_done = 1;
        chk("done_cyc", cyc, exp_done);
        chk("done_busy", busy, 1);
      end
      tick();
    end
    start = 1'b0; bf_ready = 1'b1; pipe_empty = 1'b1;
    chk("done_seen", got_done, 1);
    chk("issues", n_iss, tot);
    chk("scales", n_sc, inv ? 256 : 0);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_iv", issue_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; inverse = 1'b0; bf_ready = 1'b1; pipe_empty = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_iv", issue_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_zeta", zeta_idx, 0);
    chk("rst_layer", layer, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noissue_before_start", issue_valid, 0);
    end

    run(1'b0, 1'b0, 1'b0, 904);     // forward, free-running
    run(1'b1, 1'b0, 1'b0, 1161);    // inverse incl. scaling
    run(1'b0, 1'b1, 1'b0, 909);     // backpressure at layer 2 bf 37
    run(1'b0, 1'b0, 1'b1, 914);     // drain stall after layer 0

    // Reset in the middle of layer 3
    cyc = 0;
    inverse = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 408) tick();
    chk("pre_rst_layer", layer, 3);
    chk("pre_rst_iv", issue_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_iv", issue_valid, 0);
    chk("mid_rst_layer", layer, 0);
    chk("mid_rst_addr_a", addr_a, 0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", issue_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    run(1'b0, 1'b0, 1'b0, 904);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
